// File: rtl/vga_pkg.sv
// Shared types, bar colours and helpers for the VGA timing generator.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_FB    = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_BLACK = 2'd3
    } mode_e;

    // Bar colours as {R,G,B} full-scale flags, left to right across the line.
    localparam logic [2:0] BAR_WHITE   = 3'b111;
    localparam logic [2:0] BAR_YELLOW  = 3'b110;
    localparam logic [2:0] BAR_CYAN    = 3'b011;
    localparam logic [2:0] BAR_GREEN   = 3'b010;
    localparam logic [2:0] BAR_MAGENTA = 3'b101;
    localparam logic [2:0] BAR_RED     = 3'b100;
    localparam logic [2:0] BAR_BLUE    = 3'b001;
    localparam logic [2:0] BAR_BLACK   = 3'b000;

    localparam logic [2:0] BAR_COLOR [8] = '{
        BAR_WHITE, BAR_YELLOW, BAR_CYAN, BAR_GREEN,
        BAR_MAGENTA, BAR_RED, BAR_BLUE, BAR_BLACK
    };

    // Per-pixel control word carried through the fetch-latency delay line.
    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       valid;
        logic       fs;
        logic       ls;
        logic       use_fb;
        logic [2:0] pat;
    } pix_ctl_t;

    function automatic int unsigned vga_total(input int unsigned active,
                                              input int unsigned fp,
                                              input int unsigned sync,
                                              input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-side bus of the VGA timing generator: framebuffer fetch plus VGA pins.
interface vga_timing_gen_if #(
    parameter int unsigned COLOR_W = 8
);
    import vga_pkg::*;

    logic                   pix_en;
    mode_e                  mode;
    logic [3*COLOR_W-1:0]   vga_data;
    logic [9:0]             h_addr;
    logic [9:0]             v_addr;
    logic                   hsync;
    logic                   vsync;
    logic                   valid;
    logic [COLOR_W-1:0]     vga_r;
    logic [COLOR_W-1:0]     vga_g;
    logic [COLOR_W-1:0]     vga_b;
    logic                   frame_start;
    logic                   line_start;

    modport master (
        input  pix_en, mode, vga_data,
        output h_addr, v_addr, hsync, vsync, valid,
               vga_r, vga_g, vga_b, frame_start, line_start
    );

    modport slave (
        output pix_en, mode, vga_data,
        input  h_addr, v_addr, hsync, vsync, valid,
               vga_r, vga_g, vga_b, frame_start, line_start
    );
endinterface

// File: rtl/vga_delay.sv
// Enable-gated shift register with async active-low clear; DEPTH 0 is a plain wire.
module vga_delay #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    if (DEPTH == 0) begin : g_wire
        assign dout = din;
    end else begin : g_sr
        localparam int unsigned SRW = DEPTH * WIDTH;

        logic [DEPTH-1:0][WIDTH-1:0] sr;

        // Concatenate-and-truncate drops the oldest tap, so DEPTH=1 needs no special case.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sr <= '0;
            end else if (en) begin
                sr <= SRW'({sr, din});
            end
        end

        assign dout = sr[DEPTH-1];
    end
endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with look-ahead pixel addressing, test
// patterns and an output pipeline matched to the framebuffer read latency.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter logic        HS_POL    = 1'b0,
    parameter logic        VS_POL    = 1'b0,
    parameter int unsigned FETCH_LAT = 1,
    parameter int unsigned COLOR_W   = 8,
    parameter int unsigned CHK_SHIFT = 5
) (
    input logic              clk,
    input logic              resetn,
    vga_timing_gen_if.master vga
);
    localparam int unsigned H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
    localparam logic [11:0] HS_BEG   = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_BEG   = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  BAR_LAST = 10'(H_ACTIVE / 8 - 1);

    logic [11:0]          h_cnt;
    logic [11:0]          v_cnt;
    logic [9:0]           bar_px;
    logic [2:0]           bar_idx;
    mode_e                mode_q;
    logic                 h_wrap;
    logic                 v_wrap;
    logic                 active;
    pix_ctl_t             ctl;
    pix_ctl_t             ctl_d;
    logic                 hsync_q;
    logic                 vsync_q;
    logic                 valid_q;
    logic                 fs_q;
    logic                 ls_q;
    logic [3*COLOR_W-1:0] rgb_q;

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);
    assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);

    // Mode is only sampled on the wrap to (0,0) so a frame never mixes patterns.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            h_cnt  <= '0;
            v_cnt  <= '0;
            mode_q <= MODE_FB;
        end else if (vga.pix_en) begin
            if (h_wrap) begin
                h_cnt <= '0;
                if (v_wrap) begin
                    v_cnt  <= '0;
                    mode_q <= vga.mode;
                end else begin
                    v_cnt <= v_cnt + 12'd1;
                end
            end else begin
                h_cnt <= h_cnt + 12'd1;
            end
        end
    end

    // Running bar position replaces an h_cnt / (H_ACTIVE/8) divide.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bar_px  <= '0;
            bar_idx <= '0;
        end else if (vga.pix_en) begin
            if (h_wrap) begin
                bar_px  <= '0;
                bar_idx <= '0;
            end else if (h_cnt < H_ACT) begin
                if (bar_px == BAR_LAST) begin
                    bar_px  <= '0;
                    bar_idx <= bar_idx + 3'd1;
                end else begin
                    bar_px <= bar_px + 10'd1;
                end
            end
        end
    end

    always_comb begin
        ctl       = '0;
        ctl.hs    = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
        ctl.vs    = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
        ctl.valid = active;
        ctl.fs    = (h_cnt == '0) && (v_cnt == '0);
        ctl.ls    = (h_cnt == '0) && (v_cnt < V_ACT);
        case (mode_q)
            MODE_FB:    ctl.use_fb = 1'b1;
            MODE_BARS:  ctl.pat    = BAR_COLOR[bar_idx];
            MODE_CHECK: ctl.pat    = {3{h_cnt[CHK_SHIFT] ^ v_cnt[CHK_SHIFT]}};
            default:    ctl.pat    = BAR_BLACK;
        endcase
    end

    vga_delay #(
        .WIDTH ($bits(pix_ctl_t)),
        .DEPTH (FETCH_LAT)
    ) u_delay (
        .clk   (clk),
        .rst_n (resetn),
        .en    (vga.pix_en),
        .din   (ctl),
        .dout  (ctl_d)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            valid_q <= 1'b0;
            fs_q    <= 1'b0;
            ls_q    <= 1'b0;
            rgb_q   <= '0;
        end else if (vga.pix_en) begin
            hsync_q <= ctl_d.hs ? HS_POL : ~HS_POL;
            vsync_q <= ctl_d.vs ? VS_POL : ~VS_POL;
            valid_q <= ctl_d.valid;
            fs_q    <= ctl_d.fs;
            ls_q    <= ctl_d.ls;
            if (!ctl_d.valid) begin
                rgb_q <= '0;
            end else if (ctl_d.use_fb) begin
                rgb_q <= vga.vga_data;
            end else begin
                rgb_q <= {{COLOR_W{ctl_d.pat[2]}}, {COLOR_W{ctl_d.pat[1]}}, {COLOR_W{ctl_d.pat[0]}}};
            end
        end else begin
            fs_q <= 1'b0;
            ls_q <= 1'b0;
        end
    end

    assign vga.h_addr      = active ? h_cnt[9:0] : '0;
    assign vga.v_addr      = active ? v_cnt[9:0] : '0;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.valid       = valid_q;
    assign vga.frame_start = fs_q;
    assign vga.line_start  = ls_q;
    assign vga.vga_r       = rgb_q[3*COLOR_W-1 -: COLOR_W];
    assign vga.vga_g       = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign vga.vga_b       = rgb_q[COLOR_W-1 -: COLOR_W];
endmodule
